// File: rtl/drlp_img_bf_ctrl.sv
// Image buffer controller: arbitrates one buffer access per cycle between a
// loader write stream and a raster-scan tile reader, and registers read data
// into a one-entry valid/ready output stage.
module drlp_img_bf_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 10,
  parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * 6,
  parameter int DIM_WIDTH        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [DIM_WIDTH-1:0]        i_num_rows,
  input  logic [DIM_WIDTH-1:0]        i_num_cols,
  input  logic [ADDR_WIDTH-1:0]       i_row_stride,
  output logic                        o_busy,
  output logic                        o_done,
  input  logic                        i_ld_valid,
  input  logic [ADDR_WIDTH-1:0]       i_ld_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_ld_data,
  output logic                        o_ld_ready,
  output logic                        o_bf_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_wr_addr,
  output logic [TOTAL_DATA_WIDTH-1:0] o_bf_wr_data,
  output logic                        o_bf_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data,
  output logic                        o_px_valid,
  output logic [TOTAL_DATA_WIDTH-1:0] o_px_data,
  output logic                        o_px_last,
  input  logic                        i_px_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [DIM_WIDTH-1:0]        r_rows;
  logic [DIM_WIDTH-1:0]        r_cols;
  logic [DIM_WIDTH-1:0]        r_row;
  logic [DIM_WIDTH-1:0]        r_col;
  logic [ADDR_WIDTH-1:0]       r_stride;
  logic [ADDR_WIDTH-1:0]       r_row_base;
  logic                        r_last_grant_rd;
  logic                        r_px_valid;
  logic                        r_px_last;
  logic [TOTAL_DATA_WIDTH-1:0] r_px_data;

  logic w_wr_req;
  logic w_rd_req;
  logic w_wr_gnt;
  logic w_rd_gnt;
  logic w_last_col;
  logic w_final;
  logic w_hs;
  logic w_empty_tile;

  assign w_wr_req     = i_ld_valid;
  assign w_rd_req     = (r_state == S_RUN) && (!r_px_valid || i_px_ready);
  // Contested cycles go to the side that did not win the previous contest.
  assign w_wr_gnt     = w_wr_req && (!w_rd_req || r_last_grant_rd);
  assign w_rd_gnt     = w_rd_req && !w_wr_gnt;
  assign w_last_col   = (r_col == r_cols - DIM_WIDTH'(1));
  assign w_final      = w_last_col && (r_row == r_rows - DIM_WIDTH'(1));
  assign w_hs         = r_px_valid && i_px_ready;
  assign w_empty_tile = (i_num_rows == '0) || (i_num_cols == '0);

  assign o_px_valid = r_px_valid;
  assign o_px_data  = r_px_data;
  assign o_px_last  = r_px_last;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = w_empty_tile ? S_DONE : S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_rd_gnt && w_final) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_hs) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tile parameters and raster address counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rows     <= '0;
      r_cols     <= '0;
      r_stride   <= '0;
      r_row_base <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_rows     <= i_num_rows;
      r_cols     <= i_num_cols;
      r_stride   <= i_row_stride;
      r_row_base <= i_base_addr;
      r_row      <= '0;
      r_col      <= '0;
    end else if (w_rd_gnt) begin
      if (w_last_col) begin
        r_col      <= '0;
        r_row      <= r_row + DIM_WIDTH'(1);
        r_row_base <= r_row_base + r_stride;
      end else begin
        r_col <= r_col + DIM_WIDTH'(1);
      end
    end
  end

  // Round-robin history, updated only when both sides compete.
  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_last_grant_rd <= 1'b1;
    else if (w_wr_req && w_rd_req) r_last_grant_rd <= w_rd_gnt;
  end

  // One-entry output stage; a same-cycle read reloads it back-to-back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_px_valid <= 1'b0;
      r_px_last  <= 1'b0;
      r_px_data  <= '0;
    end else if (w_rd_gnt) begin
      r_px_valid <= 1'b1;
      r_px_last  <= w_final;
      r_px_data  <= i_bf_rd_data;
    end else if (w_hs) begin
      r_px_valid <= 1'b0;
      r_px_last  <= 1'b0;
    end
  end

  // Buffer port drive; everything idles at zero when not granted.
  always_comb begin
    o_ld_ready   = w_wr_gnt;
    o_bf_wr_en   = w_wr_gnt;
    o_bf_wr_addr = w_wr_gnt ? i_ld_addr : '0;
    o_bf_wr_data = w_wr_gnt ? i_ld_data : '0;
    o_bf_rd_en   = w_rd_gnt;
    o_bf_rd_addr = w_rd_gnt ? (r_row_base + ADDR_WIDTH'(r_col)) : '0;
  end

endmodule

// File: tb/tb_drlp_img_bf_ctrl.sv
// Randomized self-checking bench for drlp_img_bf_ctrl with a queue-based
// reference model of the tile scan, arbitration and output handshake.
module tb_drlp_img_bf_ctrl;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int TW = DW * 6;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [NW-1:0] num_rows;
  logic [NW-1:0] num_cols;
  logic [AW-1:0] row_stride;
  logic          busy;
  logic          done;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [TW-1:0] ld_data;
  logic          ld_ready;
  logic          bf_wr_en;
  logic [AW-1:0] bf_wr_addr;
  logic [TW-1:0] bf_wr_data;
  logic          bf_rd_en;
  logic [AW-1:0] bf_rd_addr;
  logic [TW-1:0] bf_rd_data;
  logic          px_valid;
  logic [TW-1:0] px_data;
  logic          px_last;
  logic          px_ready;

  logic [TW-1:0] bf_mem [0:1023];
  logic          in_tile [0:1023];

  assign bf_rd_data = bf_mem[bf_rd_addr];

  always #5 clk = ~clk;

  drlp_img_bf_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_DATA_WIDTH(TW), .DIM_WIDTH(NW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_rows(num_rows), .i_num_cols(num_cols), .i_row_stride(row_stride),
    .o_busy(busy), .o_done(done),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .o_bf_wr_en(bf_wr_en), .o_bf_wr_addr(bf_wr_addr), .o_bf_wr_data(bf_wr_data),
    .o_bf_rd_en(bf_rd_en), .o_bf_rd_addr(bf_rd_addr), .i_bf_rd_data(bf_rd_data),
    .o_px_valid(px_valid), .o_px_data(px_data), .o_px_last(px_last), .i_px_ready(px_ready)
  );

  // Reference model state
  logic [AW-1:0] exp_addr [$];
  logic [TW-1:0] exp_word [$];
  bit            exp_last [$];
  bit            last_rd;
  bit            exp_done;
  bit            exp_busy;
  bit            hold;
  logic [TW-1:0] prev_data;
  logic          prev_last;
  bit            st_fire;
  bit            seen_done;
  int            n_rd;
  bit            bp_en;
  bit            bp_used;
  int            bp_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    for (int k = 0; k < 200 && in_tile[a]; k++) a = AW'($urandom);
    return a;
  endfunction

  task automatic drive(input int ld_pct, input int rdy_pct, input bit noise);
    ld_valid = (int'($urandom_range(0, 99)) < ld_pct);
    ld_addr  = pick_addr();
    ld_data  = TW'({$urandom, $urandom});
    if (bp_en && !bp_used && px_valid) begin
      bp_cnt  = 5;
      bp_used = 1'b1;
    end
    if (bp_cnt > 0) begin
      px_ready = 1'b0;
      bp_cnt--;
    end else begin
      px_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    end
    start = noise && ($urandom_range(0, 9) == 0);
    if (start) begin
      base_addr  = AW'($urandom);
      num_rows   = NW'($urandom);
      num_cols   = NW'($urandom);
      row_stride = AW'($urandom);
    end
  endtask

  // Check one cycle against the model (inputs already driven), then advance.
  task automatic cycle();
    bit            rd_req;
    bit            e_wr;
    bit            e_rd;
    bit            hs_last;
    bit            degen;
    logic [AW-1:0] ea;
    #4;
    chk("excl", 64'(bf_wr_en & bf_rd_en), 64'd0);
    rd_req = (exp_addr.size() != 0) && (!px_valid || px_ready);
    e_wr   = ld_valid && (!rd_req || last_rd);
    e_rd   = rd_req && !e_wr;
    chk("ld_ready", 64'(ld_ready), 64'(e_wr));
    chk("wr_en", 64'(bf_wr_en), 64'(e_wr));
    chk("rd_en", 64'(bf_rd_en), 64'(e_rd));
    if (e_wr) begin
      chk("wr_addr", 64'(bf_wr_addr), 64'(ld_addr));
      chk("wr_data", 64'(bf_wr_data), 64'(ld_data));
    end else begin
      chk("wr_addr_idle", 64'(bf_wr_addr), 64'd0);
      chk("wr_data_idle", 64'(bf_wr_data), 64'd0);
    end
    if (e_rd) begin
      ea = exp_addr.pop_front();
      chk("rd_addr", 64'(bf_rd_addr), 64'(ea));
      n_rd++;
    end else begin
      chk("rd_addr_idle", 64'(bf_rd_addr), 64'd0);
    end
    if (ld_valid && rd_req) last_rd = e_rd;
    hs_last = 1'b0;
    if (px_valid && px_ready) begin
      if (exp_word.size() == 0) begin
        chk("px_extra", 64'd1, 64'd0);
      end else begin
        chk("px_data", 64'(px_data), 64'(exp_word[0]));
        chk("px_last", 64'(px_last), 64'(exp_last[0]));
        hs_last = exp_last[0];
        void'(exp_word.pop_front());
        void'(exp_last.pop_front());
      end
    end
    if (hold) begin
      chk("hold_valid", 64'(px_valid), 64'd1);
      chk("hold_data", 64'(px_data), 64'(prev_data));
      chk("hold_last", 64'(px_last), 64'(prev_last));
    end
    chk("done", 64'(done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(exp_busy));
    if (done) seen_done = 1'b1;
    hold      = px_valid && !px_ready;
    prev_data = px_data;
    prev_last = px_last;
    if (bf_wr_en) bf_mem[bf_wr_addr] = bf_wr_data;
    degen    = st_fire && (num_rows == 0 || num_cols == 0);
    exp_done = hs_last || degen;
    if (st_fire && !degen) begin
      for (int r = 0; r < int'(num_rows); r++) begin
        for (int c = 0; c < int'(num_cols); c++) begin
          ea = AW'(int'(base_addr) + r * int'(row_stride) + c);
          exp_addr.push_back(ea);
          exp_word.push_back(bf_mem[ea]);
          exp_last.push_back(r == int'(num_rows) - 1 && c == int'(num_cols) - 1);
        end
      end
      exp_busy = 1'b1;
    end else if (hs_last) begin
      exp_busy = 1'b0;
    end
    if (rst) begin
      exp_addr.delete();
      exp_word.delete();
      exp_last.delete();
      last_rd  = 1'b1;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      hold     = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input int base, input int rows, input int cols, input int stride,
                          input int ld_pct, input int rdy_pct, input bit bp, input bit abort);
    for (int i = 0; i < 1024; i++) in_tile[i] = 1'b0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        in_tile[AW'(base + r * stride + c)] = 1'b1;
    bp_en = bp; bp_used = 1'b0; bp_cnt = 0; seen_done = 1'b0; n_rd = 0;
    drive(ld_pct, rdy_pct, 1'b0);
    start      = 1'b1;
    base_addr  = AW'(base);
    num_rows   = NW'(rows);
    num_cols   = NW'(cols);
    row_stride = AW'(stride);
    st_fire    = 1'b1;
    cycle();
    st_fire = 1'b0;
    start   = 1'b0;
    for (int n = 0; n < 400 && !seen_done; n++) begin
      if (abort && n_rd >= 2) begin
        drive(ld_pct, rdy_pct, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_valid", 64'(px_valid), 64'd0);
        chk("abort_last", 64'(px_last), 64'd0);
        drive(0, rdy_pct, 1'b0);
        cycle();
        return;
      end
      drive(ld_pct, rdy_pct, 1'b1);
      cycle();
    end
    chk("scan_done_seen", 64'(seen_done), 64'd1);
    chk("words_left", 64'(exp_word.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bf_mem[i] = TW'({$urandom, $urandom});
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0;
    row_stride = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; px_ready = 1'b0;
    last_rd = 1'b1; exp_done = 1'b0; exp_busy = 1'b0; hold = 1'b0;
    prev_data = '0; prev_last = 1'b0; st_fire = 1'b0; seen_done = 1'b0; n_rd = 0;
    bp_en = 1'b0; bp_used = 1'b0; bp_cnt = 0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_px_valid", 64'(px_valid), 64'd0);
    chk("rst_px_last", 64'(px_last), 64'd0);
    chk("rst_px_data", 64'(px_data), 64'd0);
    chk("rst_wr_en", 64'(bf_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bf_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bf_wr_data), 64'd0);
    chk("rst_rd_en", 64'(bf_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(bf_rd_addr), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_scan('h010, 2, 3, 'h020,   0, 100, 1'b0, 1'b0);  // basic raster
    run_scan('h010, 2, 3, 'h020, 100, 100, 1'b0, 1'b0);  // contested, W/R alternate
    run_scan('h010, 2, 3, 'h020,   0, 100, 1'b1, 1'b0);  // 5-cycle backpressure
    run_scan('h100, 0, 4, 'h010,   0, 100, 1'b0, 1'b0);  // zero rows
    run_scan('h100, 3, 0, 'h010,  50, 100, 1'b0, 1'b0);  // zero cols
    run_scan('h3FE, 1, 4, 'h000,   0, 100, 1'b0, 1'b0);  // address wrap
    run_scan('h040, 3, 4, 'h010,   0, 100, 1'b0, 1'b1);  // reset mid-scan
    run_scan('h010, 2, 3, 'h020,   0, 100, 1'b0, 1'b0);  // clean restart
    for (int k = 0; k < 16; k++) begin
      run_scan(int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 100)), int'($urandom_range(30, 100)),
               bit'($urandom_range(0, 1)), k == 9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
